// File: rtl/audio_pkg.sv
// Shared audio-path definitions.
//   AUDIO_SAMPLE_WIDTH / AUDIO_SLOT_WIDTH : default PCM and I2S slot widths
//   state_t                               : serializer control states
//   stereo_t                              : left/right sample pair at default width
package audio_pkg;

  localparam int unsigned AUDIO_SAMPLE_WIDTH = 12;
  localparam int unsigned AUDIO_SLOT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [AUDIO_SAMPLE_WIDTH-1:0] left;
    logic [AUDIO_SAMPLE_WIDTH-1:0] right;
  } stereo_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk_i : destination clock
//   rst_ni: asynchronous active-low reset (output resets to 0)
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for stereo PCM, clocked from the audio PLL output.
//   clk, areset_n       : PLL c0 clock, asynchronous active-low reset
//   pll_locked          : PLL lock (asynchronous), gates all activity
//   s_valid/s_ready     : sample handshake into a single-entry holding buffer
//   s_left/s_right      : two's complement samples, MSB first on the wire
//   bclk/lrclk/sdata    : I2S bit clock, word select (1 = right), serial data
//   frame_start/underrun: one-cycle pulses at each frame boundary
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int unsigned SLOT_WIDTH   = AUDIO_SLOT_WIDTH,
  parameter int unsigned BCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic                    pll_locked,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned DIV_W = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam int unsigned PAIR_W = 2 * SAMPLE_WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] SAMP_B   = BIT_W'(SAMPLE_WIDTH);
  localparam logic [BIT_W-1:0] R_END_B  = BIT_W'(SLOT_WIDTH + SAMPLE_WIDTH);

  logic locked_s;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [PAIR_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic [PAIR_W-1:0] shift_q, shift_d;
  logic              ready_q, ready_d;
  logic              bclk_q, bclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;

  logic boundary;
  logic xfer;
  logic data_bit;

  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_ni(areset_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Counters sit at 0 outside RUN, so the first RUN cycle is a boundary too.
  // Lock loss suppresses the boundary so an abandoned frame cannot pulse.
  assign boundary = (state_q == RUN) && locked_s && (div_q == '0) && (bit_q == '0);
  assign xfer     = s_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    hold_d   = hold_q;
    full_d   = full_q;
    shift_d  = shift_q;
    sdata_d  = sdata_q;
    data_bit = 1'b0;

    case (state_q)
      IDLE:    if (locked_s) state_d = PRIME;
      PRIME:   if (full_q) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!locked_s) state_d = IDLE;

    if (state_q == RUN) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_ONE;
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end

    // Buffer frees at the boundary; a same-cycle transfer refills it for the next frame.
    if (boundary) begin
      shift_d = full_q ? hold_q : '0;
      full_d  = 1'b0;
    end
    if (xfer) begin
      hold_d = {s_left, s_right};
      full_d = 1'b1;
    end

    // sdata is updated one cycle ahead of the bclk falling edge so it changes with it.
    if ((state_q == RUN) && (div_q == DIV_LAST)) begin
      data_bit = ((bit_d != '0) && (bit_d <= SAMP_B)) ||
                 ((bit_d > SLOT_B) && (bit_d <= R_END_B));
      sdata_d  = data_bit ? shift_q[PAIR_W-1] : 1'b0;
      if (data_bit) shift_d = {shift_q[PAIR_W-2:0], 1'b0};
    end

    if (state_d != RUN) begin
      div_d   = '0;
      bit_d   = '0;
      sdata_d = 1'b0;
    end
    if (state_d == IDLE) begin
      full_d  = 1'b0;
      shift_d = '0;
    end

    bclk_d  = (state_d == RUN) && (div_d >= DIV_HALF);
    lrclk_d = (state_d == RUN) && (bit_d >= SLOT_B);
    ready_d = (state_d != IDLE) && !full_d;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      shift_q <= '0;
      ready_q <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
    end
  end

  assign s_ready     = ready_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign sdata       = sdata_q;
  assign frame_start = boundary;
  assign underrun    = boundary && !full_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        pll_locked;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_left;
  logic [11:0] s_right;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  audio_i2s_tx #(
    .SAMPLE_WIDTH(12),
    .SLOT_WIDTH  (16),
    .BCLK_DIV    (4)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .pll_locked (pll_locked),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {26'b0, s_ready, frame_start, underrun, bclk, lrclk, sdata};
  endfunction

  // Frame word, bit 0 of the frame in position 31: one idle bit, left MSB-first,
  // four pad bits, right MSB-first, three pad bits.
  function automatic logic [31:0] mk_word(input stereo_t p);
    return {1'b0, p.left, 4'b0000, p.right, 3'b000};
  endfunction

  // Checks one 128-cycle frame starting at the current (boundary) cycle.
  task automatic check_frame(input string tag, input logic [31:0] word, input logic exp_ur,
                             input int offer_at, input stereo_t offer, input logic stream,
                             output int xfer_c);
    logic       did;
    logic [4:0] e;
    int         k;
    xfer_c = -1;
    for (int c = 0; c < 128; c++) begin
      if (c == offer_at) begin
        s_left  = offer.left;
        s_right = offer.right;
        s_valid = 1'b1;
      end
      k = c / 4;
      e = {(c == 0), (c == 0) && exp_ur, (c % 4) >= 2, k >= 16, word[31-k]};
      chk($sformatf("%s c=%0d", tag, c),
          {27'b0, frame_start, underrun, bclk, lrclk, sdata}, {27'b0, e});
      did = s_valid && s_ready && (xfer_c < 0);
      if (did) xfer_c = c;
      tick();
      if (did && !stream) s_valid = 1'b0;
    end
  endtask

  stereo_t s2 = '{12'h7FF, 12'h800};
  stereo_t s3 = '{12'h001, 12'hFFE};
  stereo_t s4 = '{12'h5A5, 12'hC3C};
  stereo_t pairs [9] = '{
    '{12'h123, 12'h456}, '{12'hFFF, 12'h000}, '{12'h000, 12'hFFF},
    '{12'hAAA, 12'h555}, '{12'h800, 12'h001}, '{12'h7E1, 12'h18F},
    '{12'h3C3, 12'hC3C}, '{12'h9B2, 12'h64D}, '{12'hE27, 12'h0D8}
  };

  initial begin
    int   xc;
    logic ur_seen;

    areset_n   = 1'b0;
    pll_locked = 1'b0;
    s_valid    = 1'b0;
    s_left     = '0;
    s_right    = '0;

    repeat (3) tick();
    chk("reset_outs", outs(), 32'd0);
    areset_n = 1'b1;
    repeat (4) tick();
    chk("prelock_outs", outs(), 32'd0);

    // Lock-up: s_ready exactly three cycles after pll_locked rises.
    pll_locked = 1'b1;
    repeat (2) tick();
    chk("lock_ready_early", {31'b0, s_ready}, 32'd0);
    tick();
    chk("lock_ready", {31'b0, s_ready}, 32'd1);

    // Single frame A5C / 3F1.
    s_left  = 12'hA5C;
    s_right = 12'h3F1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("prime_ready_drop", {31'b0, s_ready}, 32'd0);
    chk("prime_no_fs", {31'b0, frame_start}, 32'd0);
    tick();
    check_frame("single", {1'b0, 12'b101001011100, 4'b0000, 12'b001111110001, 3'b000},
                1'b0, -1, '0, 1'b0, xc);
    chk("single_no_xfer", xc, -1);

    // Underrun: nothing offered before this boundary; late sample mid-frame.
    check_frame("underrun", 32'd0, 1'b1, 50, s2, 1'b0, xc);
    chk("underrun_xfer", xc, 50);
    check_frame("late_play", mk_word(s2), 1'b0, -1, '0, 1'b0, xc);
    chk("late_no_xfer", xc, -1);

    // Boundary-cycle handshake with an empty buffer.
    check_frame("bnd_hs", 32'd0, 1'b1, 0, s3, 1'b0, xc);
    chk("bnd_hs_xfer", xc, 0);
    check_frame("bnd_play", mk_word(s3), 1'b0, 5, pairs[0], 1'b1, xc);
    chk("stream_prefill_xfer", xc, 5);

    // Back-to-back streaming with s_valid held high.
    for (int p = 0; p < 8; p++) begin
      check_frame($sformatf("stream%0d", p), mk_word(pairs[p]), 1'b0, 0, pairs[p+1], 1'b1, xc);
      chk($sformatf("stream%0d_xfer", p), xc, 1);
    end
    s_valid = 1'b0;

    // Lock loss during bit 7 of the frame carrying pairs[8].
    chk("ll_fs", {30'b0, frame_start, underrun}, 32'd2);
    repeat (28) tick();
    chk("ll_bit7", {31'b0, sdata}, {31'b0, pairs[8].left[5]});
    pll_locked = 1'b0;
    ur_seen    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ur_seen |= underrun;
    end
    chk("ll_idle", outs(), 32'd0);
    repeat (4) tick();
    chk("ll_idle_hold", outs(), 32'd0);
    chk("ll_no_underrun", {31'b0, ur_seen}, 32'd0);

    // Relock: stale buffer is gone and the new sample plays first.
    pll_locked = 1'b1;
    repeat (2) tick();
    chk("relock_ready_early", {31'b0, s_ready}, 32'd0);
    tick();
    chk("relock_ready", {31'b0, s_ready}, 32'd1);
    s_left  = s4.left;
    s_right = s4.right;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("relock_ready_drop", {31'b0, s_ready}, 32'd0);
    tick();
    check_frame("relock_play", mk_word(s4), 1'b0, -1, '0, 1'b0, xc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
